// File: rtl/packet_buffer_pkg.sv
// Shared types and helpers for the packet buffer read path.
// Holds the scheduler state encoding and the packet header layout.
package packet_buffer_pkg;

  typedef enum logic [0:0] {
    ST_IDLE   = 1'b0,
    ST_STREAM = 1'b1
  } sched_state_e;

  typedef struct packed {
    logic [15:0] pkt_len;
    logic [7:0]  flow_id;
    logic [1:0]  lane;
    logic [5:0]  rsvd;
  } packet_header_t;

  function automatic int cdiv(input int num, input int den);
    return (num + den - 1) / den;
  endfunction

  function automatic int idx_width(input int n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/packet_order_fifo.sv
// Lane-order queue: records which lane each packet was written to.
// Registered occupancy; push while full succeeds only alongside a pop.
module packet_order_fifo
  import packet_buffer_pkg::*;
#(
  parameter int WIDTH = 2,
  parameter int DEPTH = 16
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] push_data_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] pop_data_o,
  output logic             full_o,
  output logic             empty_o,
  output logic             overflow_o
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  logic [WIDTH-1:0] mem_r [DEPTH];
  logic [PTR_W-1:0] wr_ptr_r;
  logic [PTR_W-1:0] rd_ptr_r;
  logic [CNT_W-1:0] count_r;
  logic [CNT_W-1:0] count_next_s;
  logic             full_r;
  logic             overflow_r;
  logic             do_push_s;
  logic             do_pop_s;

  assign do_pop_s  = pop_i && (count_r != {CNT_W{1'b0}});
  assign do_push_s = push_i && (!full_r || do_pop_s);

  // Occupancy update from accepted push/pop
  always_comb begin
    count_next_s = count_r;
    case ({do_push_s, do_pop_s})
      2'b10:   count_next_s = count_r + CNT_W'(1);
      2'b01:   count_next_s = count_r - CNT_W'(1);
      default: count_next_s = count_r;
    endcase
  end

  // Pointers, occupancy, full flag and sticky overflow
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr_r   <= {PTR_W{1'b0}};
      rd_ptr_r   <= {PTR_W{1'b0}};
      count_r    <= {CNT_W{1'b0}};
      full_r     <= 1'b0;
      overflow_r <= 1'b0;
    end else begin
      if (do_push_s) begin
        wr_ptr_r <= wr_ptr_r + PTR_W'(1);
      end
      if (do_pop_s) begin
        rd_ptr_r <= rd_ptr_r + PTR_W'(1);
      end
      count_r <= count_next_s;
      full_r  <= (count_next_s == CNT_W'(DEPTH));
      if (push_i && !do_push_s) begin
        overflow_r <= 1'b1;
      end
    end
  end

  // Entry storage; contents are don't-care until written
  always_ff @(posedge clk_i) begin
    if (do_push_s) begin
      mem_r[wr_ptr_r] <= push_data_i;
    end
  end

  assign pop_data_o = mem_r[rd_ptr_r];
  assign full_o     = full_r;
  assign empty_o    = (count_r == {CNT_W{1'b0}});
  assign overflow_o = overflow_r;

endmodule

// File: rtl/packet_buffer_read_scheduler.sv
// Drains lane FIFOs into one output stream, whole packets at a time,
// in the order their first beats were written.
module packet_buffer_read_scheduler
  import packet_buffer_pkg::*;
#(
  parameter int NUM_LANES             = 4,
  parameter int LANE_SELECT_IDX_WIDTH = 2,
  parameter int AXI_WIDTH             = 64,
  parameter int ORDER_FIFO_DEPTH      = 16
) (
  input  logic                             clk_i,
  input  logic                             rst_i,
  input  logic                             wr_pkt_start_i,
  input  logic [LANE_SELECT_IDX_WIDTH-1:0] wr_lane_sel_i,
  input  logic [NUM_LANES*AXI_WIDTH-1:0]   lane_data_i,
  input  logic [NUM_LANES-1:0]             lane_valid_i,
  input  logic [NUM_LANES-1:0]             lane_last_i,
  output logic [NUM_LANES-1:0]             lane_ready_o,
  output logic [AXI_WIDTH-1:0]             out_data_o,
  output logic                             out_valid_o,
  output logic                             out_last_o,
  input  logic                             out_ready_i,
  output logic                             order_full_o,
  output logic                             order_overflow_o,
  output logic [31:0]                      pkt_count_o
);

  sched_state_e                     state_r;
  sched_state_e                     state_next_s;
  logic [LANE_SELECT_IDX_WIDTH-1:0] cur_lane_r;
  logic [LANE_SELECT_IDX_WIDTH-1:0] cur_lane_next_s;
  logic [LANE_SELECT_IDX_WIDTH-1:0] head_lane_s;
  logic [31:0]                      pkt_count_r;
  logic                             q_empty_s;
  logic                             q_full_s;
  logic                             q_overflow_s;
  logic                             pop_s;
  logic                             last_xfer_s;
  logic [AXI_WIDTH-1:0]             sel_data_s;
  logic                             sel_valid_s;
  logic                             sel_last_s;
  logic [NUM_LANES-1:0]             lane_ready_s;

  packet_order_fifo #(
    .WIDTH (LANE_SELECT_IDX_WIDTH),
    .DEPTH (ORDER_FIFO_DEPTH)
  ) u_order_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (wr_pkt_start_i),
    .push_data_i (wr_lane_sel_i),
    .pop_i       (pop_s),
    .pop_data_o  (head_lane_s),
    .full_o      (q_full_s),
    .empty_o     (q_empty_s),
    .overflow_o  (q_overflow_s)
  );

  // Steer the current lane to the output; everything is quiet outside STREAM
  always_comb begin
    sel_data_s   = {AXI_WIDTH{1'b0}};
    sel_valid_s  = 1'b0;
    sel_last_s   = 1'b0;
    lane_ready_s = {NUM_LANES{1'b0}};
    for (int i = 0; i < NUM_LANES; i++) begin
      if ((state_r == ST_STREAM) && (cur_lane_r == LANE_SELECT_IDX_WIDTH'(i))) begin
        sel_data_s      = lane_data_i[i*AXI_WIDTH +: AXI_WIDTH];
        sel_valid_s     = lane_valid_i[i];
        sel_last_s      = lane_last_i[i];
        lane_ready_s[i] = out_ready_i;
      end else begin
        lane_ready_s[i] = 1'b0;
      end
    end
  end

  assign last_xfer_s = sel_valid_s && out_ready_i && sel_last_s;

  // Next state; the last beat pops the next lane directly for back-to-back packets
  always_comb begin
    state_next_s    = state_r;
    cur_lane_next_s = cur_lane_r;
    pop_s           = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (!q_empty_s) begin
          pop_s           = 1'b1;
          cur_lane_next_s = head_lane_s;
          state_next_s    = ST_STREAM;
        end else begin
          state_next_s = ST_IDLE;
        end
      end
      ST_STREAM: begin
        if (last_xfer_s) begin
          if (!q_empty_s) begin
            pop_s           = 1'b1;
            cur_lane_next_s = head_lane_s;
            state_next_s    = ST_STREAM;
          end else begin
            state_next_s = ST_IDLE;
          end
        end else begin
          state_next_s = ST_STREAM;
        end
      end
      default: begin
        state_next_s    = ST_IDLE;
        cur_lane_next_s = {LANE_SELECT_IDX_WIDTH{1'b0}};
      end
    endcase
  end

  // State, current lane and forwarded-packet counter
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_r     <= ST_IDLE;
      cur_lane_r  <= {LANE_SELECT_IDX_WIDTH{1'b0}};
      pkt_count_r <= 32'd0;
    end else begin
      state_r    <= state_next_s;
      cur_lane_r <= cur_lane_next_s;
      if (last_xfer_s) begin
        pkt_count_r <= pkt_count_r + 32'd1;
      end
    end
  end

  assign lane_ready_o     = lane_ready_s;
  assign out_data_o       = sel_data_s;
  assign out_valid_o      = sel_valid_s;
  assign out_last_o       = sel_last_s;
  assign order_full_o     = q_full_s;
  assign order_overflow_o = q_overflow_s;
  assign pkt_count_o      = pkt_count_r;

endmodule

// File: tb/tb_packet_buffer_read_scheduler.sv
// Directed bench for the read scheduler: lanes are modelled as simple beat
// sources, delivered beats are logged and compared against hand-derived values.
module tb_packet_buffer_read_scheduler;

  localparam int NL    = 4;
  localparam int SW    = 2;
  localparam int AW    = 64;
  localparam int DEPTH = 16;

  logic            clk_i = 1'b0;
  logic            rst_i;
  logic            wr_pkt_start_i;
  logic [SW-1:0]   wr_lane_sel_i;
  logic [NL*AW-1:0] lane_data_i;
  logic [NL-1:0]   lane_valid_i;
  logic [NL-1:0]   lane_last_i;
  logic [NL-1:0]   lane_ready_o;
  logic [AW-1:0]   out_data_o;
  logic            out_valid_o;
  logic            out_last_o;
  logic            out_ready_i;
  logic            order_full_o;
  logic            order_overflow_o;
  logic [31:0]     pkt_count_o;

  always #5 clk_i = ~clk_i;

  packet_buffer_read_scheduler #(
    .NUM_LANES             (NL),
    .LANE_SELECT_IDX_WIDTH (SW),
    .AXI_WIDTH             (AW),
    .ORDER_FIFO_DEPTH      (DEPTH)
  ) dut (
    .clk_i            (clk_i),
    .rst_i            (rst_i),
    .wr_pkt_start_i   (wr_pkt_start_i),
    .wr_lane_sel_i    (wr_lane_sel_i),
    .lane_data_i      (lane_data_i),
    .lane_valid_i     (lane_valid_i),
    .lane_last_i      (lane_last_i),
    .lane_ready_o     (lane_ready_o),
    .out_data_o       (out_data_o),
    .out_valid_o      (out_valid_o),
    .out_last_o       (out_last_o),
    .out_ready_i      (out_ready_i),
    .order_full_o     (order_full_o),
    .order_overflow_o (order_overflow_o),
    .pkt_count_o      (pkt_count_o)
  );

  int n_checks = 0;
  int n_errors = 0;
  int cyc_cnt  = 0;
  int pkt_len;
  int lane_avail [NL];
  int lane_seq   [NL];
  logic [63:0] log_data [$];
  logic        log_last [$];
  int          log_cyc  [$];

  task automatic chk_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic logic [63:0] mk_data(input int lane, input int seq);
    return {8'hD0, 40'h0, lane[7:0], seq[7:0]};
  endfunction

  task automatic drive_lanes();
    for (int i = 0; i < NL; i++) begin
      lane_valid_i[i]         = (lane_avail[i] > 0);
      lane_data_i[i*AW +: AW] = mk_data(i, lane_seq[i]);
      lane_last_i[i]          = (lane_avail[i] > 0) && (((lane_seq[i] + 1) % pkt_len) == 0);
    end
  endtask

  task automatic reset_lanes();
    for (int i = 0; i < NL; i++) begin
      lane_avail[i] = 0;
      lane_seq[i]   = 0;
    end
  endtask

  task automatic clear_log();
    log_data.delete();
    log_last.delete();
    log_cyc.delete();
  endtask

  // One clock: sample handshakes on the falling edge, advance lane sources after the rising edge
  task automatic cyc();
    logic [NL-1:0] fire;
    @(negedge clk_i);
    fire = lane_ready_o & lane_valid_i;
    if (!rst_i && out_valid_o && out_ready_i) begin
      log_data.push_back(out_data_o);
      log_last.push_back(out_last_o);
      log_cyc.push_back(cyc_cnt);
    end
    @(posedge clk_i);
    cyc_cnt++;
    #1;
    for (int i = 0; i < NL; i++) begin
      if (fire[i]) begin
        lane_avail[i]--;
        lane_seq[i]++;
      end
    end
    drive_lanes();
    #1;
  endtask

  task automatic push(input int lane);
    wr_pkt_start_i = 1'b1;
    wr_lane_sel_i  = lane[SW-1:0];
    cyc();
    wr_pkt_start_i = 1'b0;
  endtask

  task automatic wait_beats(input string tag, input int n, input int bound);
    for (int k = 0; k < bound && log_data.size() < n; k++) begin
      cyc();
    end
    chk_eq({tag, " beats"}, 64'(log_data.size()), 64'(n));
  endtask

  initial begin
    int order_lanes [3];
    int seen [NL];
    int push_cyc;
    int lane_exp;

    rst_i          = 1'b1;
    wr_pkt_start_i = 1'b0;
    wr_lane_sel_i  = 2'd0;
    out_ready_i    = 1'b0;
    pkt_len        = 3;
    reset_lanes();
    drive_lanes();
    #3;
    chk_eq("rst valid", 64'(out_valid_o), 64'd0);
    chk_eq("rst ready", 64'(lane_ready_o), 64'd0);
    chk_eq("rst full", 64'(order_full_o), 64'd0);
    chk_eq("rst ovf", 64'(order_overflow_o), 64'd0);
    chk_eq("rst count", 64'(pkt_count_o), 64'd0);
    cyc();
    cyc();
    rst_i = 1'b0;
    cyc();

    // Three 3-beat packets in push order 2,0,3 with no bubbles
    reset_lanes();
    pkt_len = 3;
    lane_avail[2] = 3;
    lane_avail[0] = 3;
    lane_avail[3] = 3;
    out_ready_i = 1'b1;
    drive_lanes();
    clear_log();
    push(2);
    push(0);
    push(3);
    wait_beats("order", 9, 40);
    order_lanes[0] = 2;
    order_lanes[1] = 0;
    order_lanes[2] = 3;
    for (int j = 0; j < 9; j++) begin
      if (j < log_data.size()) begin
        chk_eq("order data", log_data[j], mk_data(order_lanes[j/3], j % 3));
        chk_eq("order last", 64'(log_last[j]), 64'((j % 3) == 2));
        chk_eq("order gap", 64'(log_cyc[j] - log_cyc[0]), 64'(j));
      end
    end
    cyc();
    cyc();
    chk_eq("order count", 64'(pkt_count_o), 64'd3);
    chk_eq("order idle", 64'(out_valid_o), 64'd0);

    // First beat two cycles after the push
    reset_lanes();
    lane_avail[1] = 3;
    drive_lanes();
    clear_log();
    push_cyc = cyc_cnt;
    push(1);
    chk_eq("lat idle", 64'(out_valid_o), 64'd0);
    cyc();
    chk_eq("lat valid", 64'(out_valid_o), 64'd1);
    wait_beats("lat", 3, 20);
    if (log_cyc.size() > 0) begin
      chk_eq("lat first", 64'(log_cyc[0] - push_cyc), 64'd2);
    end
    cyc();
    chk_eq("lat count", 64'(pkt_count_o), 64'd4);

    // Downstream ready toggling 1010 over a 4-beat packet
    reset_lanes();
    pkt_len = 4;
    lane_avail[3] = 4;
    drive_lanes();
    out_ready_i = 1'b0;
    clear_log();
    push(3);
    cyc();
    for (int k = 0; k < 7; k++) begin
      out_ready_i = ((k % 2) == 0);
      #1;
      chk_eq("stall ready", 64'(lane_ready_o), 64'({out_ready_i, 3'b000}));
      chk_eq("stall valid", 64'(out_valid_o), 64'd1);
      chk_eq("stall data", out_data_o, mk_data(3, log_data.size()));
      cyc();
    end
    chk_eq("stall beats", 64'(log_data.size()), 64'd4);
    if (log_last.size() == 4) begin
      chk_eq("stall last", 64'(log_last[3]), 64'd1);
    end
    chk_eq("stall count", 64'(pkt_count_o), 64'd5);
    out_ready_i = 1'b1;

    // Fill the queue behind a stalled packet, then overflow it
    reset_lanes();
    pkt_len = 1;
    lane_avail[0] = 6;
    lane_avail[1] = 4;
    lane_avail[2] = 4;
    lane_avail[3] = 4;
    out_ready_i = 1'b0;
    drive_lanes();
    clear_log();
    push(0);
    cyc();
    for (int k = 0; k < 17; k++) begin
      push(k % 4);
      if (k == 14) begin
        chk_eq("ovf full15", 64'(order_full_o), 64'd0);
      end
      if (k == 15) begin
        chk_eq("ovf full16", 64'(order_full_o), 64'd1);
        chk_eq("ovf flag16", 64'(order_overflow_o), 64'd0);
      end
      if (k == 16) begin
        chk_eq("ovf flag17", 64'(order_overflow_o), 64'd1);
        chk_eq("ovf full17", 64'(order_full_o), 64'd1);
      end
    end
    out_ready_i = 1'b1;
    wait_beats("ovf", 17, 60);
    for (int k = 0; k < 4; k++) begin
      cyc();
    end
    chk_eq("ovf drop", 64'(log_data.size()), 64'd17);
    for (int i = 0; i < NL; i++) begin
      seen[i] = 0;
    end
    for (int j = 0; j < 17; j++) begin
      lane_exp = (j == 0) ? 0 : ((j - 1) % 4);
      if (j < log_data.size()) begin
        chk_eq("ovf data", log_data[j], mk_data(lane_exp, seen[lane_exp]));
      end
      seen[lane_exp]++;
    end
    chk_eq("ovf count", 64'(pkt_count_o), 64'd22);
    chk_eq("ovf empty", 64'(order_full_o), 64'd0);
    chk_eq("ovf sticky", 64'(order_overflow_o), 64'd1);

    // Reset on the second beat of a 4-beat packet with two more queued
    reset_lanes();
    pkt_len = 4;
    lane_avail[0] = 4;
    lane_avail[1] = 4;
    lane_avail[2] = 4;
    drive_lanes();
    clear_log();
    push(0);
    push(1);
    push(2);
    chk_eq("mid beat2", out_data_o, mk_data(0, 1));
    rst_i = 1'b1;
    #1;
    chk_eq("mid valid", 64'(out_valid_o), 64'd0);
    chk_eq("mid ready", 64'(lane_ready_o), 64'd0);
    chk_eq("mid ovf", 64'(order_overflow_o), 64'd0);
    chk_eq("mid full", 64'(order_full_o), 64'd0);
    chk_eq("mid count", 64'(pkt_count_o), 64'd0);
    cyc();
    rst_i = 1'b0;
    clear_log();
    chk_eq("mid post", 64'(out_valid_o), 64'd0);
    for (int k = 0; k < 5; k++) begin
      cyc();
    end
    chk_eq("mid drained", 64'(log_data.size()), 64'd0);
    chk_eq("mid count2", 64'(pkt_count_o), 64'd0);

    // Push and last-beat pop in the same cycle while full
    reset_lanes();
    pkt_len = 2;
    lane_avail[1] = 2;
    lane_avail[2] = 32;
    lane_avail[3] = 2;
    out_ready_i = 1'b0;
    drive_lanes();
    clear_log();
    push(1);
    cyc();
    for (int k = 0; k < 16; k++) begin
      push(2);
    end
    chk_eq("pp full", 64'(order_full_o), 64'd1);
    out_ready_i = 1'b1;
    cyc();
    wr_pkt_start_i = 1'b1;
    wr_lane_sel_i  = 2'd3;
    cyc();
    wr_pkt_start_i = 1'b0;
    chk_eq("pp still full", 64'(order_full_o), 64'd1);
    chk_eq("pp no ovf", 64'(order_overflow_o), 64'd0);
    wait_beats("pp", 36, 80);
    if (log_data.size() > 0) begin
      chk_eq("pp tail", log_data[log_data.size()-1], mk_data(3, 1));
    end
    cyc();
    chk_eq("pp count", 64'(pkt_count_o), 64'd18);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/packet_buffer_read_scheduler.md
PACKET_BUFFER_READ_SCHEDULER -- requirements
Module: packet_buffer_read_scheduler

Interface
REQ-001 Parameter NUM_LANES, default 4: number of lane FIFOs drained.
REQ-002 Parameter LANE_SELECT_IDX_WIDTH, default 2: width of lane index; SHALL be at least $clog2(NUM_LANES).
REQ-003 Parameter AXI_WIDTH, default 64: data beat width in bits.
REQ-004 Parameter ORDER_FIFO_DEPTH, default 16: lane-order queue entries, power of two.
REQ-005 clk_i  input  1  single clock; all logic on its rising edge.
REQ-006 rst_i  input  1  reset, asynchronous and active-high.
REQ-007 wr_pkt_start_i  input  1  write side accepted the first beat of a packet this cycle.
REQ-008 wr_lane_sel_i  input  LANE_SELECT_IDX_WIDTH  lane that packet was written to.
REQ-009 lane_data_i  input  [NUM_LANES] x AXI_WIDTH  lane FIFO read data.
REQ-010 lane_valid_i  input  [NUM_LANES] x 1  lane FIFO read data valid.
REQ-011 lane_last_i  input  [NUM_LANES] x 1  beat is last of packet.
REQ-012 lane_ready_o  output  [NUM_LANES] x 1  read strobe to lane FIFOs.
REQ-013 out_data_o / out_valid_o / out_last_o  output  AXI_WIDTH / 1 / 1  merged output stream.
REQ-014 out_ready_i  input  1  downstream ready.
REQ-015 order_full_o  output  1  order queue full.
REQ-016 order_overflow_o  output  1  sticky: push attempted while full.
REQ-017 pkt_count_o  output  32  packets forwarded, wraps at 2^32.

Function
REQ-018 Each wr_pkt_start_i pushes wr_lane_sel_i into the order queue; packets SHALL leave in exactly push order.
REQ-019 FSM states IDLE, STREAM; IDLE with queue non-empty SHALL pop head, latch cur_lane, enter STREAM next cycle.
REQ-020 In STREAM, out_data_o/out_valid_o/out_last_o SHALL equal lane_data_i/lane_valid_i/lane_last_i of cur_lane combinationally; all other outputs' valid SHALL be 0 in IDLE.
REQ-021 In STREAM, lane_ready_o[cur_lane] = out_ready_i; all other lane_ready_o bits SHALL be 0; in IDLE all SHALL be 0.
REQ-022 A beat transfers when out_valid_o && out_ready_i; out_valid_o SHALL not depend on out_ready_i.
REQ-023 On transfer with out_last_o=1: pkt_count_o increments; if queue non-empty, pop and remain STREAM with new cur_lane (zero-bubble); else go IDLE.
REQ-024 Queue is registered: an entry pushed in cycle N SHALL be poppable no earlier than cycle N+1.
REQ-025 Push when full and no pop same cycle: entry dropped, order_overflow_o set, held until reset.
REQ-026 Push and pop in same cycle when full SHALL both succeed; occupancy unchanged.
REQ-027 order_full_o SHALL be registered occupancy == ORDER_FIFO_DEPTH.
REQ-028 Lane valid deasserting mid-packet SHALL stall in STREAM without changing cur_lane.

Reset
REQ-029 rst_i SHALL immediately force state IDLE, queue empty, cur_lane 0, pkt_count_o 0, order_overflow_o 0, order_full_o 0, all lane_ready_o 0, out_valid_o 0.
REQ-030 Reset mid-packet SHALL abandon the packet; no output beat in the first cycle after deassertion.

Structure
REQ-031 FSM state enum and cdiv-style helpers SHALL live in packet_buffer_pkg alongside packet_header_t.
REQ-032 Order queue SHALL be sub-module packet_order_fifo (width LANE_SELECT_IDX_WIDTH, depth ORDER_FIFO_DEPTH, full/empty, async reset).

Verification
REQ-033 Push lanes 2,0,3; each lane holds a 3-beat packet -> output 9 beats, lane order 2,0,3, pkt_count_o=3, no idle cycle between packets with out_ready_i=1.
REQ-034 Single push lane 1, lane 1 valid immediately -> first out_valid_o two cycles after push.
REQ-035 Push 17 entries with depth 16, no pops -> order_full_o=1 after 16th, order_overflow_o=1 after 17th, 16 packets later drained.
REQ-036 out_ready_i toggled 1010 during a 4-beat packet -> lane_ready_o[cur] tracks it, data unchanged while stalled, 4 beats delivered.
REQ-037 Assert rst_i during beat 2 of a 4-beat packet with 2 queued -> all outputs zero, queue empty, pkt_count_o=0.
REQ-038 Queue full, push and last-beat pop same cycle -> occupancy stays 16, order_overflow_o stays 0.
